// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding,
// display select constants and the default counter width.
package run_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [2:0] ST_RST_SEQ = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_STEP    = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam int SEL_CYCLE = 0;

  // The CPU clock enable is high exactly in the executing states.
  function automatic logic st_enabled(input logic [2:0] s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at all-ones, clear on clr or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined CPU: reset sequencing, run/step/pause
// clock-enable gating, cycle and event counters with display select.
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN to halt after MAX_CYCLES
// enabled cycles and flag timeout.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NUM_CH     = 4,
  parameter int DISP_W     = 3,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              pause_req,
  input  logic              halt_req,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [DISP_W-1:0] display_switch,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  sel_count,
  output logic              done,
  output logic              timeout
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [2:0]       state_nxt;
  logic [RC_W-1:0]  rst_cnt;
  logic             rst_done;
  logic             cnt_clr;
  logic             wd_hit;
  logic [CNT_W-1:0] ev_cnt [NUM_CH];
  logic [CNT_W-1:0] sel_p0;

  assign rst_done = (rst_cnt == RC_W'(RST_CYCLES - 1));
  assign cnt_clr  = (state == ST_RST_SEQ);

`ifdef RUN_CTRL_WATCHDOG_EN
  // Fires on the edge that takes cycle_cnt to MAX_CYCLES.
  assign wd_hit = cpu_en && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // Next-state decode; halt and watchdog outrank pause, run outranks step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST_SEQ: if (rst_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (run_req)       state_nxt = ST_RUN;
        else if (step_req) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (wd_hit || halt_req) state_nxt = ST_HALT;
        else if (pause_req)     state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        if (wd_hit || halt_req) state_nxt = ST_HALT;
        else                    state_nxt = ST_IDLE;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RST_SEQ;
    endcase
  end

  // State plus registered control outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RST_SEQ;
      rst_cnt   <= '0;
      cpu_rst_n <= 1'b0;
      cpu_en    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (state == ST_RST_SEQ && !rst_done) rst_cnt <= rst_cnt + RC_W'(1);
      cpu_rst_n <= (state_nxt != ST_RST_SEQ);
      cpu_en    <= st_enabled(state_nxt);
      done      <= (state_nxt == ST_HALT);
    end
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  // Sticky flag recording that HALT came from the watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      timeout <= 1'b0;
    else if (wd_hit) timeout <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cpu_en),
    .count (cycle_cnt)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ev
    sat_counter #(.W(CNT_W)) u_ev (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cpu_en & event_in[g]),
      .count (ev_cnt[g])
    );
  end

  // Display mux: 0 is the cycle counter, 1..NUM_CH the event channels.
  always_comb begin
    sel_p0 = '0;
    if (display_switch == DISP_W'(SEL_CYCLE)) begin
      sel_p0 = cycle_cnt;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (display_switch == DISP_W'(k)) sel_p0 = ev_cnt[k-1];
      end
    end
  end

  // ---- display register stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_count <= '0;
    else        sel_count <= sel_p0;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: two instances (32-bit and 4-bit
// counters) share one stimulus stream and are compared every cycle against
// a behavioural model of the run controller.
module tb_cpu_run_ctrl;

  localparam int NCH  = 4;
  localparam int RSTC = 4;
  localparam int MAX0 = 1000000;
  localparam int MAX1 = 8;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           run_req = 1'b0, step_req = 1'b0, pause_req = 1'b0, halt_req = 1'b0;
  logic [NCH-1:0] event_in = '0;
  logic [2:0]     display_switch = '0;

  logic        rn0, en0, done0, to0, rn1, en1, done1, to1;
  logic [2:0]  s0, s1;
  logic [31:0] cyc0, sel0;
  logic [3:0]  cyc1, sel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CNT_W(32), .NUM_CH(NCH), .DISP_W(3), .RST_CYCLES(RSTC), .MAX_CYCLES(MAX0)) u0 (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .pause_req(pause_req), .halt_req(halt_req), .event_in(event_in),
    .display_switch(display_switch), .cpu_rst_n(rn0), .cpu_en(en0),
    .state(s0), .cycle_cnt(cyc0), .sel_count(sel0), .done(done0), .timeout(to0));

  cpu_run_ctrl #(.CNT_W(4), .NUM_CH(NCH), .DISP_W(3), .RST_CYCLES(RSTC), .MAX_CYCLES(MAX1)) u1 (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .pause_req(pause_req), .halt_req(halt_req), .event_in(event_in),
    .display_switch(display_switch), .cpu_rst_n(rn1), .cpu_en(en1),
    .state(s1), .cycle_cnt(cyc1), .sel_count(sel1), .done(done1), .timeout(to1));

  // Behavioural model, one slot per instance. Mode numbers follow the
  // published state encoding: 0 reset-seq, 1 idle, 2 run, 3 step, 4 halt.
  int     m_mode [2];
  int     m_left [2];
  longint m_cyc  [2];
  longint m_ev   [2][NCH];
  longint m_sel  [2];
  bit     m_to   [2];
  int     m_w    [2] = '{32, 4};
  longint m_max  [2] = '{MAX0, MAX1};

  function automatic longint sat_add(int i, longint v);
    longint lim;
    lim = (longint'(1) << m_w[i]) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_rst(int i);
    m_mode[i] = 0;
    m_left[i] = RSTC;
    m_cyc[i]  = 0;
    for (int c = 0; c < NCH; c++) m_ev[i][c] = 0;
    m_sel[i]  = 0;
    m_to[i]   = 1'b0;
  endtask

  task automatic model_step(int i);
    bit     executing, wd;
    longint old_cyc;
    int     ds;
    if (!reset) begin
      model_rst(i);
      return;
    end
    executing = (m_mode[i] == 2) || (m_mode[i] == 3);
    old_cyc   = m_cyc[i];
    ds        = int'(display_switch);
    if (ds == 0)        m_sel[i] = m_cyc[i];
    else if (ds <= NCH) m_sel[i] = m_ev[i][ds-1];
    else                m_sel[i] = 0;
    if (executing) begin
      m_cyc[i] = sat_add(i, m_cyc[i] + 1);
      for (int c = 0; c < NCH; c++)
        if (event_in[c]) m_ev[i][c] = sat_add(i, m_ev[i][c] + 1);
    end
    wd = WD && executing && (old_cyc == m_max[i] - 1);
    case (m_mode[i])
      0: begin
        m_left[i]--;
        if (m_left[i] == 0) m_mode[i] = 1;
      end
      1: if (run_req) m_mode[i] = 2; else if (step_req) m_mode[i] = 3;
      2: if (wd || halt_req) m_mode[i] = 4; else if (pause_req) m_mode[i] = 1;
      3: m_mode[i] = (wd || halt_req) ? 4 : 1;
      default: m_mode[i] = 4;
    endcase
    if (wd) m_to[i] = 1'b1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      bit ex_en;
      ex_en = (m_mode[i] == 2) || (m_mode[i] == 3);
      chk($sformatf("u%0d.state", i),     i ? 64'(s1)    : 64'(s0),    64'(m_mode[i]));
      chk($sformatf("u%0d.cpu_rst_n", i), i ? 64'(rn1)   : 64'(rn0),   64'(m_mode[i] != 0));
      chk($sformatf("u%0d.cpu_en", i),    i ? 64'(en1)   : 64'(en0),   64'(ex_en));
      chk($sformatf("u%0d.cycle_cnt", i), i ? 64'(cyc1)  : 64'(cyc0),  64'(m_cyc[i]));
      chk($sformatf("u%0d.sel_count", i), i ? 64'(sel1)  : 64'(sel0),  64'(m_sel[i]));
      chk($sformatf("u%0d.done", i),      i ? 64'(done1) : 64'(done0), 64'(m_mode[i] == 4));
      chk($sformatf("u%0d.timeout", i),   i ? 64'(to1)   : 64'(to0),   64'(m_to[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    run_req = 0; step_req = 0; pause_req = 0; halt_req = 0; event_in = '0;
    reset = 1'b0;
    #1;
    model_rst(0);
    model_rst(1);
    compare_all();
    tick();
    reset = 1'b1;
    repeat (RSTC) tick();
  endtask

  initial begin
    int en_seen;
    #2;
    model_rst(0);
    model_rst(1);
    compare_all();
    tick();
    tick();
    reset = 1'b1;

    // Reset release: held for RST_CYCLES edges, then IDLE.
    repeat (RSTC - 1) tick();
    chk("rst_hold", 64'(rn0), 64'd0);
    tick();
    chk("rst_release", 64'(rn0), 64'd1);
    chk("rst_idle", 64'(s0), 64'd1);
    chk("rst_cycles_zero", 64'(cyc0), 64'd0);
    chk("rst_sel_zero", 64'(sel0), 64'd0);

    // Run 20 enabled cycles, event 1 on the first 10, halt on the 20th.
    run_req = 1; tick(); run_req = 0;
    for (int k = 0; k < 20; k++) begin
      event_in = (k < 10) ? 4'b0010 : 4'b0000;
      halt_req = (k == 19);
      tick();
    end
    halt_req = 0; event_in = '0;
    chk("run_done", 64'(done0), 64'd1);
    chk("run_cycles", 64'(cyc0), 64'd20);
    display_switch = 3'd2;
    tick();
    chk("run_ev1_sel", 64'(sel0), 64'd10);
    display_switch = 3'd0;
    do_reset();

    // Three single steps spaced 5 cycles apart.
    en_seen = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1; tick(); step_req = 0;
      if (en0) en_seen++;
      for (int q = 0; q < 4; q++) begin
        tick();
        if (en0) en_seen++;
      end
      chk("step_back_idle", 64'(s0), 64'd1);
    end
    chk("step_en_cycles", 64'(en_seen), 64'd3);
    chk("step_cycles", 64'(cyc0), 64'd3);

    // Priorities: run over step, halt over pause, HALT is terminal.
    run_req = 1; step_req = 1; tick(); run_req = 0; step_req = 0;
    chk("prio_run", 64'(s0), 64'd2);
    tick();
    halt_req = 1; pause_req = 1; tick(); halt_req = 0; pause_req = 0;
    chk("prio_halt", 64'(s0), 64'd4);
    run_req = 1; tick(); run_req = 0;
    chk("halt_en_low", 64'(en0), 64'd0);
    chk("halt_stays", 64'(s0), 64'd4);
    do_reset();

    // Saturation on the 4-bit instance, out-of-range display select.
    run_req = 1; tick(); run_req = 0;
    repeat (20) tick();
    display_switch = 3'd7;
    tick();
    chk("sel_out_of_range0", 64'(sel0), 64'd0);
    chk("sel_out_of_range1", 64'(sel1), 64'd0);
    chk("wide_no_timeout", 64'(to0), 64'd0);
    if (WD) begin
      chk("wd_cycles", 64'(cyc1), 64'd8);
      chk("wd_timeout", 64'(to1), 64'd1);
      chk("wd_halt", 64'(s1), 64'd4);
    end else begin
      chk("sat_cycles", 64'(cyc1), 64'd15);
      chk("sat_running", 64'(s1), 64'd2);
    end
    // Asynchronous reset while the wide instance is still running.
    do_reset();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      run_req        = ($urandom_range(0, 19) == 0);
      step_req       = ($urandom_range(0, 9) == 0);
      pause_req      = ($urandom_range(0, 24) == 0);
      halt_req       = ($urandom_range(0, 59) == 0);
      event_in       = NCH'($urandom);
      display_switch = 3'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the pipelined MIPS CPU. It sequences the CPU reset, gates CPU execution through a clock enable (run, single-step or pause), and keeps a cycle counter plus NUM_CH saturating event counters (stalls, flushes, branches, …). One counter, chosen by display_switch, is driven to the seven-segment path. It sits between the board buttons/switches and the CPU top, and replaces the free-running clock and counter arrangement of the bench.

## Interface
Parameters:
- CNT_W, 32, width of the cycle and event counters.
- NUM_CH, 4, number of event-counter channels (1..7).
- DISP_W, 3, width of display_switch.
- RST_CYCLES, 4, number of cycles cpu_rst_n is held low after reset release (≥1).
- MAX_CYCLES, 1000000, watchdog limit. Used only when the watchdog is compiled in.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- run_req  in  1  level/pulse; start free run.
- step_req  in  1  pulse; execute exactly one CPU cycle.
- pause_req  in  1  pulse; leave RUN and return to IDLE.
- halt_req  in  1  CPU halt indication (syscall/terminate).
- event_in  in  NUM_CH  per-channel event strobes from the CPU.
- display_switch  in  DISP_W  counter select for display.
- cpu_rst_n  out  1  active-low reset to the CPU.
- cpu_en  out  1  CPU clock enable.
- state  out  3  current FSM state encoding.
- cycle_cnt  out  CNT_W  number of enabled CPU cycles.
- sel_count  out  CNT_W  selected counter value, registered.
- done  out  1  high in HALT.
- timeout  out  1  high when HALT was entered through the watchdog.

## Operation
- FSM states: RST_SEQ=0, IDLE=1, RUN=2, STEP=3, HALT=4.
- RST_SEQ: cpu_rst_n=0, cpu_en=0, all counters are cleared. Moves to IDLE after RST_CYCLES edges.
- IDLE: cpu_en=0.
  - run_req moves to RUN.
  - Otherwise, step_req moves to STEP.
  - run_req has priority over step_req.
- RUN: cpu_en=1.
  - halt_req moves to HALT.
  - Otherwise, pause_req moves to IDLE.
  - halt_req has priority over pause_req. run_req and step_req are ignored.
- STEP: cpu_en=1 for exactly one cycle, then IDLE. If halt_req is high in that cycle, the next state is HALT.
- HALT: cpu_en=0 and done=1. This state is terminal; only reset leaves it.
- cycle_cnt: +1 on every edge where cpu_en=1.
- Event counter i: +1 on every edge where cpu_en=1 and event_in[i]=1. Strobes arriving while cpu_en=0 are dropped.
- All counters saturate at all-ones. They do not wrap.
- display_switch selects the value loaded into sel_count:
  - 0 selects cycle_cnt.
  - k in 1..NUM_CH selects event counter k-1.
  - Any other value gives 0.

## Timing
- Reset values: state=RST_SEQ, cpu_rst_n=0, cpu_en=0, cycle_cnt=0, all event counters=0, sel_count=0, done=0, timeout=0.
- Asserting reset mid-operation returns everything to these values immediately (asynchronously).
- cpu_rst_n rises on the RST_CYCLES-th rising edge after reset deasserts. That is the same edge where state becomes IDLE.
- All outputs are registered. A request sampled at edge t changes state and cpu_en at edge t; the CPU is first enabled in cycle t..t+1.
- halt_req sampled at edge t drops cpu_en at t. The enabled cycle that ended at t has already been counted.
- A step_req pulse yields exactly one cpu_en-high cycle and cycle_cnt +1.
- A step_req held high yields alternating STEP/IDLE, i.e. one step every 2 cycles.
- sel_count has 1-cycle latency from display_switch or counter change.

## Configuration
- RUN_CTRL_WATCHDOG_EN defined:
  - In RUN, when cycle_cnt reaches MAX_CYCLES-1 and is incrementing, the FSM enters HALT and sets timeout=1. The final cycle_cnt is MAX_CYCLES.
  - halt_req in the same cycle also enters HALT, and timeout is still set.
  - STEP is checked the same way.
- RUN_CTRL_WATCHDOG_EN undefined: timeout is tied to 0, no comparator is built, and MAX_CYCLES is unused.

## Structure
- Shared package run_ctrl_pkg holds:
  - the state encoding constants (3 bits),
  - the display select constant SEL_CYCLE=0,
  - the default CNT_W.
- One sub-module, sat_counter: parameter W; inputs clk, reset, clr, inc; output count saturating at all-ones. It is instantiated NUM_CH+1 times (cycle counter plus event channels).

## Test plan
- Reset release with RST_CYCLES=4 → cpu_rst_n=0 for 4 edges, then cpu_rst_n=1, state=IDLE; all counters and sel_count read 0.
- run_req pulse, event_in[1] high for 10 of 20 enabled cycles, then halt_req → done=1, cycle_cnt=20; display_switch=2 gives sel_count=10 one cycle later.
- Three step_req pulses spaced 5 cycles apart → exactly 3 cpu_en-high cycles, cycle_cnt=3, state back in IDLE after each.
- run_req and step_req both high in IDLE → RUN. In RUN, halt_req and pause_req both high → HALT. In HALT, run_req is ignored and cpu_en stays 0.
- CNT_W=4, run 20 cycles → cycle_cnt saturates at 15. With display_switch=7 and NUM_CH=4, sel_count=0.
- With RUN_CTRL_WATCHDOG_EN defined and MAX_CYCLES=8, run with no halt → HALT after 8 enabled cycles, timeout=1. Asserting reset mid-RUN clears everything asynchronously.
